// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB-style slave in front of a 2**AWIDTH x DWIDTH word memory,
// inserting WAIT_STATES p_ready-low cycles into every access phase.
module apb_slave_mem #(
    parameter int AWIDTH      = 8,
    parameter int DWIDTH      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_sel,
    input  logic              p_en,
    input  logic              p_write,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata,
    output logic              p_ready
);

    localparam int         DEPTH = 2 ** AWIDTH;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                p_ready_q, p_ready_d;
    logic [DWIDTH-1:0]   rdata_q, rdata_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;
    logic [DWIDTH-1:0]   mem_q [DEPTH];
    logic                mem_we;

    always_comb begin
        // NOTE: every _d defaults to its current value so no branch can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        p_ready_d = p_ready_q;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        mem_we    = 1'b0;

        // A setup phase restarts the transfer from either state.
        if (p_sel && !p_en) begin
            state_d   = ACCESS;
            addr_d    = addr;
            write_d   = p_write;
            wdata_d   = wdata;
            cnt_d     = WS;
            p_ready_d = (WS == 4'd0);
            if (!p_write && WS == 4'd0) begin
                rdata_d = mem_q[addr];
            end
        end else if (state_q == ACCESS) begin
            if (!p_sel) begin
                state_d   = IDLE;
                p_ready_d = 1'b0;
            end else if (!p_ready_q) begin
                cnt_d     = cnt_q - 4'd1;
                p_ready_d = (cnt_q == 4'd1);
                if (!write_q && cnt_q == 4'd1) begin
                    rdata_d = mem_q[addr_q];
                end
            end else begin
                // Completion edge: writes commit from the latched address/data.
                mem_we    = write_q;
                state_d   = IDLE;
                p_ready_d = 1'b0;
            end
        end else begin
            p_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            p_ready_q <= 1'b0;
            rdata_q   <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            // NOTE: the memory is cleared on reset, so it maps to resettable flops, not a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates so every flop sees pre-edge values of the others.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p_ready_q <= p_ready_d;
            rdata_q   <= rdata_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            if (mem_we) begin
                mem_q[addr_q] <= wdata_q;
            end
        end
    end

    assign rdata   = rdata_q;
    assign p_ready = p_ready_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: directed vectors against two instances, one with zero and one with
// one wait state, plus hand-written abort, address-change and async-reset sequences.
module tb_apb_slave_mem;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MAX_WAIT = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [1:0]          p_sel, p_en, p_write;
    logic [1:0][AW-1:0]  addr_v;
    logic [1:0][DW-1:0]  wdata_v;
    logic [DW-1:0]       rdata0, rdata1;
    logic                p_ready0, p_ready1;

    apb_slave_mem #(.AWIDTH(AW), .DWIDTH(DW), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .p_sel(p_sel[0]), .p_en(p_en[0]), .p_write(p_write[0]),
        .addr(addr_v[0]), .wdata(wdata_v[0]), .rdata(rdata0), .p_ready(p_ready0)
    );

    apb_slave_mem #(.AWIDTH(AW), .DWIDTH(DW), .WAIT_STATES(1)) dut1 (
        .clk(clk), .rst(rst), .p_sel(p_sel[1]), .p_en(p_en[1]), .p_write(p_write[1]),
        .addr(addr_v[1]), .wdata(wdata_v[1]), .rdata(rdata1), .p_ready(p_ready1)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          w;       // which instance: 0 -> WAIT_STATES=0, 1 -> WAIT_STATES=1
        logic        wr;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        string       name;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic get_ready(input int w);
        return (w == 0) ? p_ready0 : p_ready1;
    endfunction

    function automatic logic [31:0] get_rdata(input int w);
        return (w == 0) ? rdata0 : rdata1;
    endfunction

    // Counts access-phase cycles until p_ready is seen; caller is #1 after the setup edge.
    task automatic wait_ready(input int w, output int cycles);
        cycles = 1;
        while (!get_ready(w) && cycles < MAX_WAIT) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic xfer(input int w, input logic wr, input logic [7:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input string name);
        int cycles;
        logic [31:0] rd_before;
        rd_before = get_rdata(w);
        @(posedge clk); #1;
        p_sel[w] = 1'b1; p_en[w] = 1'b0; p_write[w] = wr; addr_v[w] = a; wdata_v[w] = d;
        @(posedge clk); #1;
        p_en[w] = 1'b1;
        wait_ready(w, cycles);
        check({name, " ready_cycle"}, 32'(cycles), 32'(w + 1));
        if (wr) check({name, " rdata_held"}, get_rdata(w), rd_before);
        else    check({name, " rdata"}, get_rdata(w), exp_rd);
        @(posedge clk); #1;
        p_sel[w] = 1'b0; p_en[w] = 1'b0;
        check({name, " ready_drop"}, 32'(get_ready(w)), 32'd0);
    endtask

    initial begin
        int cycles;
        rst = 1'b0;
        p_sel = '0; p_en = '0; p_write = '0; addr_v = '0; wdata_v = '0;

        vecs[0] = '{1, 1'b0, 8'h00, 32'h0,        32'h0,        "ws1_rd_00"};
        vecs[1] = '{1, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0,        "ws1_wr_10"};
        vecs[2] = '{1, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF, "ws1_rd_10"};
        vecs[3] = '{0, 1'b1, 8'h00, 32'hA5A5A5A5, 32'h0,        "ws0_wr_00"};
        vecs[4] = '{0, 1'b1, 8'hFF, 32'h5A5A0FF0, 32'h0,        "ws0_wr_ff"};
        vecs[5] = '{0, 1'b0, 8'h00, 32'h0,        32'hA5A5A5A5, "ws0_rd_00"};
        vecs[6] = '{0, 1'b0, 8'hFF, 32'h0,        32'h5A5A0FF0, "ws0_rd_ff"};
        vecs[7] = '{0, 1'b0, 8'h80, 32'h0,        32'h0,        "ws0_rd_80"};
        vecs[8] = '{1, 1'b0, 8'h00, 32'h0,        32'h0,        "ws1_rd_00_again"};

        // Reset held for three clocks.
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        check("rst ready0", 32'(p_ready0), 32'd0);
        check("rst ready1", 32'(p_ready1), 32'd0);
        check("rst rdata0", rdata0, 32'h0);
        check("rst rdata1", rdata1, 32'h0);

        for (int i = 0; i < 9; i++) begin
            xfer(vecs[i].w, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].exp_rd, vecs[i].name);
        end

        // Abort: p_sel dropped in the wait cycle of a write to 8'h20.
        @(posedge clk); #1;
        p_sel[1] = 1'b1; p_en[1] = 1'b0; p_write[1] = 1'b1; addr_v[1] = 8'h20; wdata_v[1] = 32'h12345678;
        @(posedge clk); #1;
        check("abort ready_wait", 32'(p_ready1), 32'd0);
        p_sel[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("abort ready_after", 32'(p_ready1), 32'd0);
        end
        xfer(1, 1'b0, 8'h20, 32'h0, 32'h0, "abort rd_20");

        // Bus address/data change during ACCESS must not redirect the write.
        @(posedge clk); #1;
        p_sel[1] = 1'b1; p_en[1] = 1'b0; p_write[1] = 1'b1; addr_v[1] = 8'h30; wdata_v[1] = 32'hCAFEF00D;
        @(posedge clk); #1;
        p_en[1] = 1'b1; addr_v[1] = 8'h31; wdata_v[1] = 32'h11111111;
        wait_ready(1, cycles);
        check("addrchg ready_cycle", 32'(cycles), 32'd2);
        @(posedge clk); #1;
        p_sel[1] = 1'b0; p_en[1] = 1'b0;
        xfer(1, 1'b0, 8'h30, 32'h0, 32'hCAFEF00D, "addrchg rd_30");
        xfer(1, 1'b0, 8'h31, 32'h0, 32'h0,        "addrchg rd_31");

        // Async reset asserted between edges while a read holds p_ready high.
        @(posedge clk); #1;
        p_sel[1] = 1'b1; p_en[1] = 1'b0; p_write[1] = 1'b0; addr_v[1] = 8'h30;
        @(posedge clk); #1;
        p_en[1] = 1'b1;
        wait_ready(1, cycles);
        check("midrst ready_before", 32'(p_ready1), 32'd1);
        check("midrst rdata_before", rdata1, 32'hCAFEF00D);
        #3 rst = 1'b0;
        #1;
        check("midrst ready", 32'(p_ready1), 32'd0);
        check("midrst rdata", rdata1, 32'h0);
        p_sel[1] = 1'b0; p_en[1] = 1'b0;
        #2 rst = 1'b1;
        xfer(1, 1'b0, 8'h30, 32'h0,        32'h0,        "postrst rd_30");
        xfer(1, 1'b1, 8'h40, 32'hABCD0123, 32'h0,        "postrst wr_40");
        xfer(1, 1'b0, 8'h40, 32'h0,        32'hABCD0123, "postrst rd_40");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
